vram_arbiter: RTL and testbench



---
 rtl/common.sv | 23 ++
 rtl/vram_prio.sv | 32 +++
 rtl/vram_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// Shared types for the VRAM arbiter.
//   vram_src_t   : identifies the requester that owns the current SRAM access.
//   vram_state_t : the SRAM access sequencer states.
package common;

    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_SCR,
        SRC_UP,
        SRC_CPU,
        SRC_DMA
    } vram_src_t;

    typedef enum logic [1:0] {
        VS_IDLE,
        VS_T1,
        VS_T2,
        VS_T3
    } vram_state_t;

    localparam int unsigned STARVE_CNT_W = 4;

endpackage

// File: rtl/vram_prio.sv
// Combinational winner selection for the VRAM arbiter.
// Ports:
//   scr_req_i, up_req_i, cpu_req_i, dma_req_i : pending request levels
//   starve_ovr_i : DMA has been starved; lift it above up and cpu
//   src_o        : winning source, SRC_NONE when nothing is pending
module vram_prio
    import common::*;
(
    input  logic      scr_req_i,
    input  logic      up_req_i,
    input  logic      cpu_req_i,
    input  logic      dma_req_i,
    input  logic      starve_ovr_i,
    output vram_src_t src_o
);

    always_comb begin
        src_o = SRC_NONE;
        if (scr_req_i) begin
            src_o = SRC_SCR;               // screen is never pre-empted
        end else if (dma_req_i && starve_ovr_i) begin
            src_o = SRC_DMA;
        end else if (up_req_i) begin
            src_o = SRC_UP;
        end else if (cpu_req_i) begin
            src_o = SRC_CPU;
        end else if (dma_req_i) begin
            src_o = SRC_DMA;
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: time-multiplexes the shared SRAM between screen fetch, ULAplus
// palette writes, CPU and DMA using a fixed 3-cycle access (T1, T2, T3).
// Optional feature macro: VRAM_DMA_EN (DMA port and anti-starvation counter).
// Ports:
//   clk28, rst                  : clock, asynchronous active-high reset
//   scr_* / up_* / cpu_* / dma_*: requester levels, address, write data, acks
//   rdata                       : last byte read from the SRAM
//   va, vd_in, vd_out, vd_oe    : SRAM address and data pad interface
//   n_vrd, n_vwr                : active-low SRAM strobes (registered)
//   busy                        : access in progress (T1..T3)
module vram_arbiter
    import common::*;
#(
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned STARVE_LIMIT = 15
) (
    input  logic              clk28,
    input  logic              rst,
    input  logic              scr_req,
    input  logic [ADDR_W-1:0] scr_addr,
    output logic              scr_ack,
    input  logic              up_req,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [7:0]        up_wdata,
    output logic              up_ack,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic              dma_ack,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] va,
    input  logic [7:0]        vd_in,
    output logic [7:0]        vd_out,
    output logic              vd_oe,
    output logic              n_vrd,
    output logic              n_vwr,
    output logic              busy
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    vram_state_t       state_q, state_d;
    vram_src_t         src_q, src_d;
    vram_src_t         winner;
    logic [ADDR_W-1:0] va_q, va_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              n_vrd_q, n_vrd_d;
    logic              n_vwr_q, n_vwr_d;
    logic              vd_oe_q, vd_oe_d;
    logic [3:0]        ack_q, ack_d;     // {dma, cpu, up, scr}
    logic              dma_req_eff;
    logic              starve_ovr;
    logic              grant;

    vram_prio u_prio (
        .scr_req_i    (scr_req),
        .up_req_i     (up_req),
        .cpu_req_i    (cpu_req),
        .dma_req_i    (dma_req_eff),
        .starve_ovr_i (starve_ovr),
        .src_o        (winner)
    );

    // Arbitration happens in IDLE and again in T3 for back-to-back accesses.
    assign grant = ((state_q == VS_IDLE) || (state_q == VS_T3)) && (winner != SRC_NONE);

`ifdef VRAM_DMA_EN
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;

    assign dma_req_eff = dma_req;
    assign starve_ovr  = dma_req && (starve_q == STARVE_MAX);
    assign dma_ack     = ack_q[3];

    always_comb begin
        starve_d = starve_q;
        if (!dma_req) begin
            starve_d = '0;
        end else if (grant) begin
            if (winner == SRC_DMA) begin
                starve_d = '0;
            end else if (starve_q != STARVE_MAX) begin
                starve_d = starve_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    logic unused_dma;

    assign dma_req_eff = 1'b0;
    assign starve_ovr  = 1'b0;
    assign dma_ack     = 1'b0;
    assign unused_dma  = ^{dma_req, ack_q[3], STARVE_MAX};
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        va_d    = va_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        ack_d   = '0;

        unique case (state_q)
            VS_IDLE: if (grant) state_d = VS_T1;
            VS_T1:   state_d = VS_T2;
            VS_T2: begin
                state_d = VS_T3;
                if (!we_q) rdata_d = vd_in;
                // Registered ack lands in T3 together with the fresh rdata.
                unique case (src_q)
                    SRC_SCR: ack_d[0] = 1'b1;
                    SRC_UP:  ack_d[1] = 1'b1;
                    SRC_CPU: ack_d[2] = 1'b1;
                    SRC_DMA: ack_d[3] = 1'b1;
                    default: ack_d    = '0;
                endcase
            end
            VS_T3:   state_d = grant ? VS_T1 : VS_IDLE;
            default: state_d = VS_IDLE;
        endcase

        if (grant) begin
            src_d = winner;
            unique case (winner)
                SRC_SCR: begin va_d = scr_addr; wdata_d = 8'h00;     we_d = 1'b0;   end
                SRC_UP:  begin va_d = up_addr;  wdata_d = up_wdata;  we_d = 1'b1;   end
                SRC_CPU: begin va_d = cpu_addr; wdata_d = cpu_wdata; we_d = cpu_we; end
                SRC_DMA: begin va_d = dma_addr; wdata_d = dma_wdata; we_d = dma_we; end
                default: ;
            endcase
        end

        // Strobes derive from the next state so they are clean flop outputs.
        n_vrd_d = !(((state_d == VS_T1) || (state_d == VS_T2)) && !we_d);
        n_vwr_d = !(((state_d == VS_T1) || (state_d == VS_T2)) && we_d);
        vd_oe_d = (state_d != VS_IDLE) && we_d;
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state_q <= VS_IDLE;
            src_q   <= SRC_NONE;
            va_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            n_vrd_q <= 1'b1;
            n_vwr_q <= 1'b1;
            vd_oe_q <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            va_q    <= va_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            n_vrd_q <= n_vrd_d;
            n_vwr_q <= n_vwr_d;
            vd_oe_q <= vd_oe_d;
            ack_q   <= ack_d;
        end
    end

    assign scr_ack = ack_q[0];
    assign up_ack  = ack_q[1];
    assign cpu_ack = ack_q[2];
    assign rdata   = rdata_q;
    assign va      = va_q;
    assign vd_out  = wdata_q;
    assign vd_oe   = vd_oe_q;
    assign n_vrd   = n_vrd_q;
    assign n_vwr   = n_vwr_q;
    assign busy    = (state_q != VS_IDLE);

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: a transaction-level model (priority
// list, starvation count, per-requester remaining accesses) predicts every
// grant and the pin activity of each 3-cycle access.
module tb_vram_arbiter;

    localparam int ADDR_W = 19;
`ifdef VRAM_DMA_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif

    logic              clk28 = 1'b0;
    logic              rst;
    logic [3:0]        req_v;                 // {dma, cpu, up, scr}
    logic [ADDR_W-1:0] r_addr [4];
    logic [7:0]        r_data [4];
    logic              r_we   [4];
    logic [7:0]        vd_in;
    logic              scr_ack, up_ack, cpu_ack, dma_ack;
    logic [7:0]        rdata, vd_out;
    logic [ADDR_W-1:0] va;
    logic              vd_oe, n_vrd, n_vwr, busy;
    logic [3:0]        acks;

    assign acks = {dma_ack, cpu_ack, up_ack, scr_ack};

    always #5 clk28 = ~clk28;

    vram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(15)) dut (
        .clk28     (clk28),
        .rst       (rst),
        .scr_req   (req_v[0]),
        .scr_addr  (r_addr[0]),
        .scr_ack   (scr_ack),
        .up_req    (req_v[1]),
        .up_addr   (r_addr[1]),
        .up_wdata  (r_data[1]),
        .up_ack    (up_ack),
        .cpu_req   (req_v[2]),
        .cpu_we    (r_we[2]),
        .cpu_addr  (r_addr[2]),
        .cpu_wdata (r_data[2]),
        .cpu_ack   (cpu_ack),
        .dma_req   (req_v[3]),
        .dma_we    (r_we[3]),
        .dma_addr  (r_addr[3]),
        .dma_wdata (r_data[3]),
        .dma_ack   (dma_ack),
        .rdata     (rdata),
        .va        (va),
        .vd_in     (vd_in),
        .vd_out    (vd_out),
        .vd_oe     (vd_oe),
        .n_vrd     (n_vrd),
        .n_vwr     (n_vwr),
        .busy      (busy)
    );

    // Model state
    int         rem      [4];
    int         raise_at [4];
    bit         raised   [4];
    int         cnt;
    logic [7:0] rdata_exp;
    int         vd_force;
    string      cur_tag;
    int         checks;
    int         passed;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s/%s: observed %0h expected %0h", cur_tag, name, obs, exp);
    endtask

    function automatic bit pend(int i);
        return raised[i] && (rem[i] > 0);
    endfunction

    function automatic bit elig(int i);
        return pend(i) && ((i != 3) || DMA_EN);
    endfunction

    function automatic bit we_of(int i);
        if (i == 0) return 1'b0;
        if (i == 1) return 1'b1;
        return r_we[i];
    endfunction

    // Fixed priority scr > up > cpu > dma; a starved DMA jumps up and cpu only.
    function automatic int pick();
        if (elig(0)) return 0;
        if (elig(3) && cnt >= 15) return 3;
        if (elig(1)) return 1;
        if (elig(2)) return 2;
        if (elig(3)) return 3;
        return -1;
    endfunction

    task automatic apply_reqs();
        for (int i = 0; i < 4; i++) req_v[i] = pend(i);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            rem[i] = 0; raise_at[i] = 0; raised[i] = 1'b0;
        end
        apply_reqs();
    endtask

    // Called at a negedge in IDLE; raises requests and follows every grant.
    task automatic run_round(input string tag);
        int         g;
        int         w;
        bit         we;
        logic [7:0] v;
        g = 0;
        cur_tag = tag;
        for (int i = 0; i < 4; i++) raised[i] = (raise_at[i] == 0);
        apply_reqs();
        forever begin
            w = pick();
            if (w < 0) break;
            if (!elig(3) || w == 3) cnt = 0;
            else if (cnt < 15) cnt = cnt + 1;
            we = we_of(w);
            @(negedge clk28);  // T1
            check("t1_busy", 32'(busy), 32'd1);
            check("t1_va", 32'(va), 32'(r_addr[w]));
            check("t1_nvrd", 32'(n_vrd), 32'(we));
            check("t1_nvwr", 32'(n_vwr), 32'(!we));
            check("t1_oe", 32'(vd_oe), 32'(we));
            check("t1_ack", 32'(acks), 32'd0);
            if (we) check("t1_vdout", 32'(vd_out), 32'(r_data[w]));
            v = (vd_force >= 0) ? 8'(vd_force) : 8'($urandom);
            vd_in = v;
            @(negedge clk28);  // T2
            check("t2_nvrd", 32'(n_vrd), 32'(we));
            check("t2_nvwr", 32'(n_vwr), 32'(!we));
            check("t2_oe", 32'(vd_oe), 32'(we));
            check("t2_ack", 32'(acks), 32'd0);
            if (!we) rdata_exp = v;
            @(negedge clk28);  // T3
            check("t3_ack", 32'(acks), 32'd1 << w);
            check("t3_rdata", 32'(rdata), 32'(rdata_exp));
            check("t3_va", 32'(va), 32'(r_addr[w]));
            check("t3_nvrd", 32'(n_vrd), 32'd1);
            check("t3_nvwr", 32'(n_vwr), 32'd1);
            check("t3_oe", 32'(vd_oe), 32'(we));
            if (we) check("t3_vdout", 32'(vd_out), 32'(r_data[w]));
            vd_in = 8'($urandom);
            rem[w] = rem[w] - 1;
            g = g + 1;
            for (int i = 0; i < 4; i++)
                if (!raised[i] && raise_at[i] == g) raised[i] = 1'b1;
            apply_reqs();
        end
        @(negedge clk28);
        check("end_busy", 32'(busy), 32'd0);
        check("end_ack", 32'(acks), 32'd0);
        check("end_rdata", 32'(rdata), 32'(rdata_exp));
        if (!DMA_EN) cnt = 0;
        clear_model();
        vd_force = -1;
    endtask

    task automatic randomize_ports();
        for (int i = 0; i < 4; i++) begin
            r_addr[i] = ADDR_W'($urandom);
            r_data[i] = 8'($urandom);
            r_we[i]   = 1'($urandom);
        end
    endtask

    initial begin
        checks = 0; passed = 0; cnt = 0; rdata_exp = 8'h00; vd_force = -1;
        cur_tag = "reset";
        rst = 1'b1; vd_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            r_addr[i] = '0; r_data[i] = '0; r_we[i] = 1'b0;
        end
        clear_model();
        @(negedge clk28);
        @(negedge clk28);
        check("va", 32'(va), 32'd0);
        check("vdout", 32'(vd_out), 32'd0);
        check("rdata", 32'(rdata), 32'd0);
        check("oe", 32'(vd_oe), 32'd0);
        check("nvrd", 32'(n_vrd), 32'd1);
        check("nvwr", 32'(n_vwr), 32'd1);
        check("busy", 32'(busy), 32'd0);
        check("acks", 32'(acks), 32'd0);
        rst = 1'b0;
        @(negedge clk28);
        check("idle_busy", 32'(busy), 32'd0);

        // Single CPU read
        r_addr[2] = 19'h1ABCD; r_we[2] = 1'b0; rem[2] = 1; vd_force = 8'h5A;
        run_round("cpu_read");
        check("rdata_5a", 32'(rdata), 32'h5A);

        // Single DMA write: rdata must keep 5A
        r_addr[3] = 19'h0F00D; r_we[3] = 1'b1; r_data[3] = 8'h3C; rem[3] = 1;
        run_round("dma_write");
        check("rdata_kept", 32'(rdata), 32'h5A);

        // scr, up, cpu together: granted in priority order, back to back
        randomize_ports();
        rem[0] = 1; rem[1] = 1; rem[2] = 1;
        run_round("three_way");

        // CPU held with DMA pending: DMA forced on the 16th grant
        randomize_ports();
        rem[2] = 20; rem[3] = 1;
        run_round("starve");

        // Screen raised exactly at the override point still wins first
        randomize_ports();
        rem[2] = 17; rem[3] = 1; rem[0] = 1; raise_at[0] = 15;
        run_round("starve_scr");

        // Random request mixes
        for (int r = 0; r < 25; r++) begin
            randomize_ports();
            for (int i = 0; i < 4; i++) rem[i] = $urandom_range(0, 2);
            run_round($sformatf("rand%0d", r));
        end

        // Reset in T2 of a CPU write
        cur_tag = "rst_mid";
        r_addr[2] = 19'h12345; r_we[2] = 1'b1; r_data[2] = 8'hA7;
        req_v = 4'b0100;
        @(negedge clk28);
        check("t1_nvwr", 32'(n_vwr), 32'd0);
        @(negedge clk28);
        check("t2_nvwr", 32'(n_vwr), 32'd0);
        check("t2_oe", 32'(vd_oe), 32'd1);
        rst = 1'b1;
        #1;
        check("async_nvwr", 32'(n_vwr), 32'd1);
        check("async_oe", 32'(vd_oe), 32'd0);
        check("async_nvrd", 32'(n_vrd), 32'd1);
        check("async_busy", 32'(busy), 32'd0);
        req_v = 4'b0000;
        rdata_exp = 8'h00; cnt = 0;
        @(negedge clk28);
        check("rst_ack", 32'(acks), 32'd0);
        check("rst_va", 32'(va), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk28);
        check("post_busy", 32'(busy), 32'd0);
        check("post_ack", 32'(acks), 32'd0);
        @(negedge clk28);
        check("post_ack2", 32'(acks), 32'd0);

        // Arbiter still works after the aborted access
        randomize_ports();
        rem[2] = 1; rem[1] = 1;
        run_round("after_rst");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
